// File: rtl/snax_acc_stream_shell_ctrl.sv
// Stream shell controller: per-channel FIFOs between streamer and accelerator core,
// a CSR-launched job FSM with output-beat completion detection, and RO status CSRs.
module snax_acc_stream_shell_ctrl #(
    parameter int unsigned NumInCh      = 4,
    parameter int unsigned NumOutCh     = 2,
    parameter int unsigned DataWidth    = 512,
    parameter int unsigned FifoDepth    = 2,
    parameter int unsigned RegRWCount   = 5,
    parameter int unsigned RegROCount   = 2,
    parameter int unsigned RegDataWidth = 32,
    parameter int unsigned CntWidth     = 32
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NumInCh*DataWidth-1:0]         stream2acc_data_i,
    input  logic [NumInCh-1:0]                   stream2acc_valid_i,
    output logic [NumInCh-1:0]                   stream2acc_ready_o,
    output logic [NumInCh*DataWidth-1:0]         core_in_data_o,
    output logic [NumInCh-1:0]                   core_in_valid_o,
    input  logic [NumInCh-1:0]                   core_in_ready_i,
    input  logic [NumOutCh*DataWidth-1:0]        core_out_data_i,
    input  logic [NumOutCh-1:0]                  core_out_valid_i,
    output logic [NumOutCh-1:0]                  core_out_ready_o,
    output logic [NumOutCh*DataWidth-1:0]        acc2stream_data_o,
    output logic [NumOutCh-1:0]                  acc2stream_valid_o,
    input  logic [NumOutCh-1:0]                  acc2stream_ready_i,
    input  logic [RegRWCount*RegDataWidth-1:0]   csr_reg_set_i,
    input  logic                                 csr_reg_set_valid_i,
    output logic                                 csr_reg_set_ready_o,
    output logic [RegROCount*RegDataWidth-1:0]   csr_reg_ro_set_o,
    output logic [RegRWCount*RegDataWidth-1:0]   core_cfg_o,
    output logic                                 core_cfg_valid_o,
    input  logic                                 core_cfg_ready_i
);
    localparam int unsigned NumCh    = NumInCh + NumOutCh;
    localparam int unsigned PtrWidth = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int unsigned LvlWidth = (FifoDepth > 0) ? $clog2(FifoDepth + 1) : 1;
    localparam int unsigned PopWidth = $clog2(NumOutCh + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, CFG = 2'd1, BUSY = 2'd2} state_e;

    state_e                              state_q;
    logic [RegRWCount*RegDataWidth-1:0]  cfg_q;
    logic [CntWidth-1:0]                 beat_cnt_q;
    logic [CntWidth-1:0]                 perf_cnt_q;
    logic [CntWidth-1:0]                 target;
    logic [CntWidth-1:0]                 beat_next;
    logic [CntWidth-1:0]                 perf_next;
    logic                                cfg_valid_q;
    logic                                csr_ready_q;
    logic                                job_run;

    logic [DataWidth-1:0] fifo_wdata [NumCh];
    logic [DataWidth-1:0] fifo_rdata [NumCh];
    logic [NumCh-1:0]     fifo_push_valid;
    logic [NumCh-1:0]     fifo_push_ready;
    logic [NumCh-1:0]     fifo_pop_valid;
    logic [NumCh-1:0]     fifo_pop_ready;

    function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(FifoDepth - 1)) ? '0 : p + PtrWidth'(1);
    endfunction

    function automatic logic [PopWidth-1:0] popcount(input logic [NumOutCh-1:0] v);
        logic [PopWidth-1:0] n;
        n = '0;
        for (int i = 0; i < NumOutCh; i++) n = n + PopWidth'(v[i]);
        return n;
    endfunction

    // Input channels: core side only sees data while a job is running.
    for (genvar i = 0; i < NumInCh; i++) begin : g_in_map
        assign fifo_wdata[i]                            = stream2acc_data_i[i*DataWidth +: DataWidth];
        assign fifo_push_valid[i]                       = stream2acc_valid_i[i];
        assign stream2acc_ready_o[i]                    = fifo_push_ready[i];
        assign core_in_data_o[i*DataWidth +: DataWidth] = fifo_rdata[i];
        assign core_in_valid_o[i]                       = fifo_pop_valid[i] & job_run;
        assign fifo_pop_ready[i]                        = core_in_ready_i[i] & job_run;
    end

    for (genvar j = 0; j < NumOutCh; j++) begin : g_out_map
        assign fifo_wdata[NumInCh+j]                       = core_out_data_i[j*DataWidth +: DataWidth];
        assign fifo_push_valid[NumInCh+j]                  = core_out_valid_i[j];
        assign core_out_ready_o[j]                         = fifo_push_ready[NumInCh+j];
        assign acc2stream_data_o[j*DataWidth +: DataWidth] = fifo_rdata[NumInCh+j];
        assign acc2stream_valid_o[j]                       = fifo_pop_valid[NumInCh+j];
        assign fifo_pop_ready[NumInCh+j]                   = acc2stream_ready_i[j];
    end

    for (genvar c = 0; c < NumCh; c++) begin : g_fifo
        if (FifoDepth == 0) begin : g_pass
            assign fifo_rdata[c]      = fifo_wdata[c];
            assign fifo_pop_valid[c]  = fifo_push_valid[c];
            assign fifo_push_ready[c] = fifo_pop_ready[c];
        end else begin : g_buf
            logic [DataWidth-1:0] mem [FifoDepth];
            logic [PtrWidth-1:0]  wr_ptr_q;
            logic [PtrWidth-1:0]  rd_ptr_q;
            logic [LvlWidth-1:0]  level_q;
            logic                 push;
            logic                 pop;

            // Ready depends only on fullness, so a full FIFO refuses a push even while popping.
            assign fifo_push_ready[c] = (level_q != LvlWidth'(FifoDepth));
            assign fifo_pop_valid[c]  = (level_q != '0);
            assign fifo_rdata[c]      = mem[rd_ptr_q];
            assign push               = fifo_push_valid[c] & fifo_push_ready[c];
            assign pop                = fifo_pop_valid[c] & fifo_pop_ready[c];

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    level_q  <= '0;
                end else begin
                    if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
                    if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
                    if (push && !pop) level_q <= level_q + LvlWidth'(1);
                    if (pop && !push) level_q <= level_q - LvlWidth'(1);
                end
            end

            always_ff @(posedge clk_i) begin
                if (push) mem[wr_ptr_q] <= fifo_wdata[c];
            end
        end
    end

    assign target    = CntWidth'(cfg_q[RegDataWidth +: RegDataWidth]);
    assign beat_next = beat_cnt_q + CntWidth'(popcount(acc2stream_valid_o & acc2stream_ready_i));
    assign perf_next = (&perf_cnt_q) ? perf_cnt_q : perf_cnt_q + CntWidth'(1);
    assign job_run   = (state_q == BUSY);

    // Job control: latch config, hand it to the core, count output beats to completion.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cfg_q       <= '0;
            beat_cnt_q  <= '0;
            perf_cnt_q  <= '0;
            cfg_valid_q <= 1'b0;
            csr_ready_q <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (csr_reg_set_valid_i) begin
                        cfg_q       <= csr_reg_set_i;
                        beat_cnt_q  <= '0;
                        perf_cnt_q  <= '0;
                        cfg_valid_q <= 1'b1;
                        csr_ready_q <= 1'b0;
                        state_q     <= CFG;
                    end
                end
                CFG: begin
                    perf_cnt_q <= perf_next;
                    if (core_cfg_ready_i) begin
                        cfg_valid_q <= 1'b0;
                        if (target == '0) begin
                            csr_ready_q <= 1'b1;
                            state_q     <= IDLE;
                        end else begin
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    perf_cnt_q <= perf_next;
                    beat_cnt_q <= beat_next;
                    if (beat_next >= target) begin
                        csr_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    cfg_valid_q <= 1'b0;
                    csr_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign core_cfg_o          = cfg_q;
    assign core_cfg_valid_o    = cfg_valid_q;
    assign csr_reg_set_ready_o = csr_ready_q;
    assign csr_reg_ro_set_o    = (RegROCount*RegDataWidth)'({RegDataWidth'(perf_cnt_q),
                                                             RegDataWidth'(state_q != IDLE)});

endmodule
